crc3_frame_sequencer: RTL and testbench

- Controller that sequences the CRC-3 shift engine (tt_um_crc3-style datapath behind the latch-based clock gate) for one framed message at a time.
- Accepts a start command with a message length, then pulls message bits MSB-first over a valid/ready handshake.
- Drives the engine's gate enable and serial data bit, appends 3 zero padding bits, captures the remainder and holds it until acknowledged.
- Sits between the host-side bit source and the CRC engine; the engine computes, this block controls it.

---
 rtl/crc3_frame_sequencer.sv | 175 +++++++++++++++++
 tb/tb_crc3_frame_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/crc3_frame_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// crc3_frame_sequencer : frames one message through an external CRC-3 engine.
// Optional shadow self-check under CRC_SELFCHECK_EN.            Rev 1.0
// ----------------------------------------------------------------------------
module crc3_frame_sequencer #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int CRC_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             abort,
  input  logic             msg_valid,
  input  logic             msg_bit,
  output logic             msg_ready,
  output logic             crc_clr,
  output logic             crc_en,
  output logic             crc_bit,
  input  logic [CRC_W-1:0] crc_rem,
  output logic             busy,
  output logic             err_len,
  output logic             res_valid,
  output logic [CRC_W-1:0] res_crc,
  output logic             res_err,
  input  logic             res_ack
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_CLR    = 3'd1;
  localparam logic [2:0] c_MSG    = 3'd2;
  localparam logic [2:0] c_PAD    = 3'd3;
  localparam logic [2:0] c_SETTLE = 3'd4;
  localparam logic [2:0] c_DONE   = 3'd5;

  localparam logic [LEN_W-1:0] c_MAX_LEN  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] c_PAD_LAST = LEN_W'(CRC_W - 1);
  localparam logic [LEN_W-1:0] c_ONE      = LEN_W'(1);

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [CRC_W-1:0] res_crc_q, res_crc_d;
  logic             err_len_q, err_len_d;

  logic w_len_ok;
  logic w_hs;
  logic w_abortable;

  assign w_len_ok    = (msg_len != '0) && (msg_len <= c_MAX_LEN);
  assign w_hs        = (state_q == c_MSG) && msg_valid;
  assign w_abortable = (state_q == c_CLR) || (state_q == c_MSG) ||
                       (state_q == c_PAD) || (state_q == c_SETTLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= c_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      res_crc_q <= '0;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      res_crc_q <= res_crc_d;
      err_len_q <= err_len_d;
    end
  end

  // cnt_q counts message bits in MSG, then is reused for the padding bits in PAD
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    res_crc_d = res_crc_q;
    err_len_d = 1'b0;
    case (state_q)
      c_IDLE: begin
        if (start) begin
          if (w_len_ok) begin
            len_d   = msg_len;
            cnt_d   = '0;
            state_d = c_CLR;
          end else begin
            err_len_d = 1'b1;
          end
        end
      end
      c_CLR: state_d = c_MSG;
      c_MSG: begin
        if (w_hs) begin
          cnt_d = cnt_q + c_ONE;
          if (cnt_q + c_ONE == len_q) begin
            cnt_d   = '0;
            state_d = c_PAD;
          end
        end
      end
      c_PAD: begin
        cnt_d = cnt_q + c_ONE;
        if (cnt_q == c_PAD_LAST) begin
          cnt_d   = '0;
          state_d = c_SETTLE;
        end
      end
      c_SETTLE: begin
        res_crc_d = crc_rem;
        state_d   = c_DONE;
      end
      c_DONE: begin
        if (res_ack) state_d = c_IDLE;
      end
      default: state_d = c_IDLE;
    endcase
    if (abort && w_abortable) begin
      state_d   = c_IDLE;
      cnt_d     = cnt_q;
      res_crc_d = res_crc_q;
    end
  end

  // crc_en depends only on state and msg_valid so the engine's gate enable stays clean
  always_comb begin
    msg_ready = (state_q == c_MSG);
    crc_clr   = (state_q == c_CLR);
    crc_en    = w_hs || (state_q == c_PAD);
    crc_bit   = w_hs && msg_bit;
    busy      = (state_q != c_IDLE);
    res_valid = (state_q == c_DONE);
  end

  assign err_len = err_len_q;
  assign res_crc = res_crc_q;

`ifdef CRC_SELFCHECK_EN
  localparam logic [CRC_W-1:0] c_POLY = CRC_W'(3'b011);

  logic [CRC_W-1:0] shadow_q, shadow_d;
  logic             res_err_q, res_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q  <= '0;
      res_err_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      res_err_q <= res_err_d;
    end
  end

  always_comb begin
    shadow_d  = shadow_q;
    res_err_d = res_err_q;
    if (crc_clr) begin
      shadow_d = '0;
    end else if (crc_en) begin
      shadow_d = {shadow_q[CRC_W-2:0], crc_bit} ^ (shadow_q[CRC_W-1] ? c_POLY : '0);
    end
    if ((state_q == c_SETTLE) && !abort) begin
      res_err_d = (shadow_q != crc_rem);
    end else if ((state_q == c_DONE) && res_ack) begin
      res_err_d = 1'b0;
    end
  end

  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_crc3_frame_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_crc3_frame_sequencer : scoreboard bench with a behavioural CRC-3 engine.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_crc3_frame_sequencer;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;
  localparam int CRC_W   = 3;

  logic             clk = 1'b0;
  logic             rst, start, abort, msg_valid, msg_bit, res_ack;
  logic [LEN_W-1:0] msg_len;
  logic [CRC_W-1:0] crc_rem;
  logic             msg_ready, crc_clr, crc_en, crc_bit, busy, err_len;
  logic             res_valid, res_err;
  logic [CRC_W-1:0] res_crc;

  int errors = 0;
  int checks = 0;
  int edges  = 0;

  logic             exp_bit_q[$];
  logic [CRC_W-1:0] exp_crc_q[$];

  logic [2:0] eng_q;
  logic       corrupt;

  always #5 clk = ~clk;

  crc3_frame_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CRC_W(CRC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .msg_len(msg_len), .abort(abort),
    .msg_valid(msg_valid), .msg_bit(msg_bit), .msg_ready(msg_ready),
    .crc_clr(crc_clr), .crc_en(crc_en), .crc_bit(crc_bit), .crc_rem(crc_rem),
    .busy(busy), .err_len(err_len), .res_valid(res_valid), .res_crc(res_crc),
    .res_err(res_err), .res_ack(res_ack)
  );

  // Engine stand-in: x^3+x+1, MSB first, shifts on edges that end a crc_en cycle
  always @(posedge clk) begin
    if (rst || crc_clr) eng_q <= 3'b000;
    else if (crc_en)    eng_q <= {eng_q[1:0], crc_bit} ^ (eng_q[2] ? 3'b011 : 3'b000);
  end
  assign crc_rem = corrupt ? 3'b100 : eng_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (crc_en) begin
        if (exp_bit_q.size() == 0) check("crc_en_spurious", crc_en, 0);
        else                       check("crc_bit", crc_bit, exp_bit_q.pop_front());
      end
      if (crc_clr) check("clr_vs_en", crc_en, 0);
    end
  end

  task automatic run_frame(input int len, input logic [15:0] bits, input int stall_at,
                           input int stall_n, input logic [2:0] exp_crc,
                           input logic exp_err, input int hold);
    start   = 1'b1;
    msg_len = LEN_W'(len);
    tick();
    edges = 0;
    start = 1'b0;
    check("clr_pulse", crc_clr, 1);
    check("busy_clr", busy, 1);
    tick();
    exp_crc_q.push_back(exp_crc);
    for (int i = 0; i < len; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          msg_valid = 1'b0;
          #1;
          check("stall_en", crc_en, 0);
          check("stall_ready", msg_ready, 1);
          tick();
        end
      end
      msg_valid = 1'b1;
      msg_bit   = bits[len-1-i];
      exp_bit_q.push_back(bits[len-1-i]);
      if (i == len - 1) repeat (CRC_W) exp_bit_q.push_back(1'b0);
      tick();
    end
    msg_valid = 1'b0;
    msg_bit   = 1'b0;
    for (int k = 0; k < 40 && !res_valid; k++) tick();
    check("res_valid", res_valid, 1);
    check("latency", edges, len + 5 + ((stall_at >= 0 && stall_at < len) ? stall_n : 0));
    check("res_crc", res_crc, exp_crc_q.pop_front());
    check("res_err", res_err, exp_err);
    check("pad_drained", exp_bit_q.size(), 0);
    for (int h = 0; h < hold; h++) begin
      start   = (h % 2 == 0);
      msg_len = 5'd5;
      tick();
      check("hold_valid", res_valid, 1);
      check("hold_crc", res_crc, exp_crc);
      check("hold_en", crc_en, 0);
    end
    start   = 1'b0;
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    check("ack_valid", res_valid, 0);
    check("ack_busy", busy, 0);
    check("ack_err", res_err, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, res_valid, 0);
    check({tag, "_crc"}, res_crc, 0);
    check({tag, "_err_len"}, err_len, 0);
    check({tag, "_en"}, crc_en, 0);
    check({tag, "_clr"}, crc_clr, 0);
    check({tag, "_ready"}, msg_ready, 0);
    check({tag, "_bit"}, crc_bit, 0);
    check({tag, "_res_err"}, res_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; msg_valid = 1'b0; msg_bit = 1'b0;
    res_ack = 1'b0; msg_len = '0; corrupt = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Nominal 10101 frame, then 20-cycle hold in DONE with start pulses
    run_frame(5, 16'b10101, -1, 0, 3'b101, 1'b0, 20);

    // Same frame with a two-cycle stall after bit 2
    run_frame(5, 16'b10101, 2, 2, 3'b101, 1'b0, 0);

    // Illegal lengths
    for (int j = 0; j < 2; j++) begin
      start   = 1'b1;
      msg_len = (j == 0) ? 5'd0 : 5'd17;
      tick();
      start = 1'b0;
      check("err_len_pulse", err_len, 1);
      check("err_busy", busy, 0);
      check("err_clr", crc_clr, 0);
      check("err_en", crc_en, 0);
      tick();
      check("err_len_clear", err_len, 0);
      check("err_busy2", busy, 0);
    end

    // Abort after three handshakes
    start   = 1'b1;
    msg_len = 5'd5;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      msg_valid = 1'b1;
      msg_bit   = (i != 1);
      exp_bit_q.push_back(i != 1);
      tick();
    end
    msg_valid = 1'b0;
    abort     = 1'b1;
    #1;
    check("abort_busy_pre", busy, 1);
    tick();
    abort = 1'b0;
    check("abort_idle", busy, 0);
    for (int i = 0; i < 4; i++) begin
      check("abort_en", crc_en, 0);
      check("abort_valid", res_valid, 0);
      tick();
    end
    check("abort_crc_kept", res_crc, 3'b101);
    check("abort_drained", exp_bit_q.size(), 0);

    // Short frame after abort
    run_frame(1, 16'b1, -1, 0, 3'b011, 1'b0, 0);

    // Reset during the second PAD cycle
    start   = 1'b1;
    msg_len = 5'd5;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      msg_valid = 1'b1;
      msg_bit   = (i % 2 == 0);
      exp_bit_q.push_back(i % 2 == 0);
      if (i == 4) repeat (CRC_W) exp_bit_q.push_back(1'b0);
      tick();
    end
    msg_valid = 1'b0;
    msg_bit   = 1'b0;
    tick();
    check("pad2_en", crc_en, 1);
    rst = 1'b1;
    tick();
    check_all_zero("pad_reset");
    rst = 1'b0;
    exp_bit_q.delete();
    tick();
    check("post_reset_en", crc_en, 0);
    check("post_reset_busy", busy, 0);

`ifdef CRC_SELFCHECK_EN
    corrupt = 1'b1;
    run_frame(5, 16'b10101, -1, 0, 3'b100, 1'b1, 0);
    corrupt = 1'b0;
    run_frame(5, 16'b10101, -1, 0, 3'b101, 1'b0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
